mem_byte_sequencer: RTL and testbench

Multi-cycle load/store controller between the core's memory stage and the byte-wide data memory. The data memory performs only byte accesses: byte read with sign extension, byte write on the clock edge. This block breaks each lb/lh/lw/lbu/lhu/sb/sh/sw request into 1, 2 or 4 sequential byte accesses, assembles little-endian read data, and signals completion with a busy/done handshake. The core holds its pipeline while Busy is high.

---
 rtl/mem_byte_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mem_byte_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer between the memory stage and a byte-wide data memory.
// Ports: clk/reset; Req* request in; Busy/Done/Err/RData out; Mem* byte-access bus.
module mem_byte_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        ReqRead,
    input  logic        ReqWrite,
    input  logic [2:0]  ReqFunct3,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] RData,
    output logic [31:0] MemSum,
    output logic [31:0] MemWData,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [2:0]  MemFunct3,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  k;
    logic [1:0]  last;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        is_read;
    logic [31:0] asm_q;

    logic        req_ok;
    logic [1:0]  req_last;
    logic        f3_ok;
    logic        aligned;
    logic [1:0]  k_nxt;
    logic [31:0] nxt_asm;
    logic [31:0] ext_data;
    logic [31:0] wdata_sh;

    // Only the low byte of the memory read port carries data.
    logic        unused_rdata;
    assign unused_rdata = ^MemRData[31:8];

    assign Busy      = (state != IDLE);
    assign MemFunct3 = 3'b000;

    // Request decode, evaluated only in the acceptance cycle.
    always_comb begin
        f3_ok    = 1'b0;
        aligned  = 1'b1;
        req_last = 2'd0;
        unique case (ReqFunct3)
            3'b000: f3_ok = 1'b1;
            3'b001: begin
                f3_ok    = 1'b1;
                aligned  = ~ReqAddr[0];
                req_last = 2'd1;
            end
            3'b010: begin
                f3_ok    = 1'b1;
                aligned  = (ReqAddr[1:0] == 2'b00);
                req_last = 2'd3;
            end
            3'b100: f3_ok = ReqRead;
            3'b101: begin
                f3_ok    = ReqRead;
                aligned  = ~ReqAddr[0];
                req_last = 2'd1;
            end
            default: f3_ok = 1'b0;
        endcase
        req_ok = (ReqRead ^ ReqWrite) & f3_ok & aligned;
    end

    assign k_nxt    = k + 2'd1;
    assign wdata_sh = wdata >> {k_nxt, 3'b000};

    // The byte being read this cycle lands in lane k at the closing edge.
    assign nxt_asm = asm_q | ({24'b0, MemRData[7:0]} << {k, 3'b000});

    always_comb begin
        ext_data = nxt_asm;
        unique case (f3[1:0])
            2'b00: ext_data = {{24{nxt_asm[7] & ~f3[2]}}, nxt_asm[7:0]};
            2'b01: ext_data = {{16{nxt_asm[15] & ~f3[2]}}, nxt_asm[15:0]};
            default: ext_data = nxt_asm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= 2'd0;
            last     <= 2'd0;
            base     <= 32'd0;
            wdata    <= 32'd0;
            f3       <= 3'd0;
            is_read  <= 1'b0;
            asm_q    <= 32'd0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            RData    <= 32'd0;
            MemSum   <= 32'd0;
            MemWData <= 32'd0;
            MemWrite <= 1'b0;
            MemRead  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    Done <= 1'b0;
                    Err  <= 1'b0;
                    if (Req) begin
                        base    <= ReqAddr;
                        wdata   <= ReqWData;
                        f3      <= ReqFunct3;
                        is_read <= ReqRead;
                        k       <= 2'd0;
                        last    <= req_last;
                        asm_q   <= 32'd0;
                        if (req_ok) begin
                            state    <= ACCESS;
                            MemSum   <= ReqAddr;
                            MemRead  <= ReqRead;
                            MemWrite <= ReqWrite;
                            MemWData <= {24'b0, ReqWData[7:0]};
                        end else begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                            RData <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    asm_q <= nxt_asm;
                    if (k == last) begin
                        state    <= DONE;
                        Done     <= 1'b1;
                        Err      <= 1'b0;
                        RData    <= is_read ? ext_data : 32'd0;
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        MemWData <= 32'd0;
                    end else begin
                        k        <= k_nxt;
                        MemSum   <= base + {30'b0, k_nxt};
                        MemWData <= {24'b0, wdata_sh[7:0]};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Err   <= 1'b0;
                    k     <= 2'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Self-checking bench for mem_byte_sequencer with a byte memory model
// and a request-level reference model compared every cycle.
module tb_mem_byte_sequencer;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        ReqRead;
    logic        ReqWrite;
    logic [2:0]  ReqFunct3;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [31:0] RData;
    logic [31:0] MemSum;
    logic [31:0] MemWData;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  MemFunct3;
    logic [31:0] MemRData;

    mem_byte_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .ReqRead   (ReqRead),
        .ReqWrite  (ReqWrite),
        .ReqFunct3 (ReqFunct3),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .RData     (RData),
        .MemSum    (MemSum),
        .MemWData  (MemWData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .MemFunct3 (MemFunct3),
        .MemRData  (MemRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory driven by the DUT strobes.
    logic [7:0] mem [0:255];
    logic       mem_clr;

    assign MemRData = {{24{mem[MemSum[7:0]][7]}}, mem[MemSum[7:0]]};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[3] <= 8'h0A;
        end else if (MemWrite) begin
            mem[MemSum[7:0]] <= MemWData[7:0];
        end
    end

    // Reference memory, updated at request level.
    logic [7:0] ref_mem [0:255];

    typedef struct {
        bit          busy;
        bit          done;
        bit          err;
        bit          rd;
        bit          wr;
        logic [31:0] sum;
        logic [31:0] wd;
        logic [31:0] rdata;
    } exp_t;

    exp_t expq [$];

    int          n_checks;
    int          n_fail;
    int          done_cnt;
    int          n_req;
    bit          mon_en;
    logic [31:0] last_rdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Builds the per-cycle expectation for one accepted request.
    task automatic model_req(input bit rd, input bit wr,
                             input logic [2:0] f3,
                             input logic [31:0] addr,
                             input logic [31:0] wdata,
                             output int len);
        int          n;
        bit          sgn;
        logic [31:0] v;
        logic [7:0]  a;
        exp_t        e;
        n   = 0;
        sgn = 0;
        if (rd && !wr) begin
            case (f3)
                3'd0: begin n = 1; sgn = 1; end
                3'd1: begin n = 2; sgn = 1; end
                3'd2: n = 4;
                3'd4: n = 1;
                3'd5: n = 2;
                default: n = 0;
            endcase
        end else if (wr && !rd) begin
            case (f3)
                3'd0: n = 1;
                3'd1: n = 2;
                3'd2: n = 4;
                default: n = 0;
            endcase
        end
        if (n != 0 && (addr % n) != 0) n = 0;
        n_req++;
        if (n == 0) begin
            e = '{busy: 1, done: 1, err: 1, rd: 0, wr: 0,
                  sum: 0, wd: 0, rdata: 0};
            expq.push_back(e);
            len = 1;
            return;
        end
        v = 0;
        for (int i = 0; i < n; i++) begin
            a = 8'(addr + 32'(i));
            e = '{busy: 1, done: 0, err: 0, rd: rd, wr: wr,
                  sum: addr + 32'(i),
                  wd: wr ? {24'b0, wdata[8*i +: 8]} : 32'd0,
                  rdata: 0};
            expq.push_back(e);
            if (rd) v = v | ({24'b0, ref_mem[a]} << (8 * i));
            if (wr) ref_mem[a] = wdata[8*i +: 8];
        end
        if (sgn && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        e = '{busy: 1, done: 1, err: 0, rd: 0, wr: 0,
              sum: 0, wd: 0, rdata: rd ? v : 32'd0};
        expq.push_back(e);
        len = n + 1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        ReqRead   = rd;
        ReqWrite  = wr;
        ReqFunct3 = f3;
        ReqAddr   = addr;
        ReqWData  = wdata;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit wait_done);
        int len;
        @(negedge clk);
        drive(rd, wr, f3, addr, wdata);
        Req = 1'b1;
        @(posedge clk);
        #1;
        model_req(rd, wr, f3, addr, wdata, len);
        Req = 1'b0;
        drive(0, 0, 3'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        if (wait_done) repeat (len) @(posedge clk);
    endtask

    // One compare per cycle against the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (expq.size() != 0) e = expq.pop_front();
            else e = '{busy: 0, done: 0, err: 0, rd: 0, wr: 0,
                       sum: 0, wd: 0, rdata: 0};
            chk("busy", {31'b0, Busy}, {31'b0, e.busy});
            chk("done", {31'b0, Done}, {31'b0, e.done});
            chk("memread", {31'b0, MemRead}, {31'b0, e.rd});
            chk("memwrite", {31'b0, MemWrite}, {31'b0, e.wr});
            chk("memfunct3", {29'b0, MemFunct3}, 32'd0);
            if (e.rd || e.wr) chk("memsum", MemSum, e.sum);
            if (e.wr) chk("memwdata", MemWData, e.wd);
            if (e.done) begin
                chk("err", {31'b0, Err}, {31'b0, e.err});
                chk("rdata", RData, e.rdata);
                last_rdata = RData;
                done_cnt++;
            end
        end
    end

    initial begin
        int len;
        int d0;
        n_checks   = 0;
        n_fail     = 0;
        done_cnt   = 0;
        n_req      = 0;
        mon_en     = 0;
        last_rdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[3] = 8'h0A;
        reset   = 1'b1;
        mem_clr = 1'b1;
        Req     = 1'b0;
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_clr = 1'b0;
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_err", {31'b0, Err}, 32'd0);
        chk("rst_rdata", RData, 32'd0);
        chk("rst_memsum", MemSum, 32'd0);
        chk("rst_memwdata", MemWData, 32'd0);
        mon_en = 1;

        issue(1, 0, 3'd2, 32'd0, 32'd0, 1);
        chk("lw0", last_rdata, 32'h0A00_0000);

        issue(0, 1, 3'd2, 32'd8, 32'h1234_5678, 1);
        chk("sw8", last_rdata, 32'h0);
        issue(1, 0, 3'd0, 32'd11, 32'd0, 1);
        chk("lb11", last_rdata, 32'h0000_0012);
        issue(1, 0, 3'd1, 32'd10, 32'd0, 1);
        chk("lh10", last_rdata, 32'h0000_1234);
        issue(1, 0, 3'd4, 32'd8, 32'd0, 1);
        chk("lbu8", last_rdata, 32'h0000_0078);

        issue(0, 1, 3'd1, 32'd4, 32'h0000_FF80, 1);
        issue(1, 0, 3'd1, 32'd4, 32'd0, 1);
        chk("lh4", last_rdata, 32'hFFFF_FF80);
        issue(1, 0, 3'd5, 32'd4, 32'd0, 1);
        chk("lhu4", last_rdata, 32'h0000_FF80);
        issue(1, 0, 3'd0, 32'd4, 32'd0, 1);
        chk("lb4", last_rdata, 32'hFFFF_FF80);

        d0 = done_cnt;
        issue(1, 0, 3'd2, 32'd2, 32'd0, 1);
        chk("lw2_rdata", last_rdata, 32'h0);
        issue(1, 0, 3'd3, 32'd0, 32'd0, 1);
        issue(1, 1, 3'd0, 32'd0, 32'd0, 1);
        issue(0, 1, 3'd1, 32'd5, 32'hFFFF, 1);
        issue(1, 0, 3'd6, 32'd0, 32'd0, 1);
        chk("illegal_dones", 32'(done_cnt - d0), 32'd5);
        chk("mem5_untouched", {24'b0, mem[5]}, 32'h0000_00FF);

        // Store cut short by reset on its second byte edge.
        @(negedge clk);
        drive(0, 1, 3'd2, 32'd16, 32'hAABB_CCDD);
        Req = 1'b1;
        @(posedge clk);
        #1;
        Req = 1'b0;
        expq.push_back('{busy: 1, done: 0, err: 0, rd: 0, wr: 1,
                         sum: 32'd16, wd: 32'hDD, rdata: 0});
        expq.push_back('{busy: 1, done: 0, err: 0, rd: 0, wr: 1,
                         sum: 32'd17, wd: 32'hCC, rdata: 0});
        ref_mem[16] = 8'hDD;
        ref_mem[17] = 8'hCC;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m16", {24'b0, mem[16]}, 32'hDD);
        chk("rst_m17", {24'b0, mem[17]}, 32'hCC);
        chk("rst_m18", {24'b0, mem[18]}, 32'h00);
        chk("rst_m19", {24'b0, mem[19]}, 32'h00);

        // Req pulses while a word load is in flight.
        d0 = done_cnt;
        issue(1, 0, 3'd2, 32'd8, 32'd0, 0);
        @(negedge clk);
        drive(0, 1, 3'd0, 32'd50, 32'h99);
        Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        @(negedge clk);
        Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_ignore_dones", 32'(done_cnt - d0), 32'd1);
        chk("busy_ignore_lw", last_rdata, 32'h1234_5678);
        chk("busy_ignore_mem50", {24'b0, mem[50]}, 32'h0);

        // Req held high across two requests.
        @(negedge clk);
        drive(1, 0, 3'd4, 32'd8, 32'd0);
        Req = 1'b1;
        @(posedge clk);
        #1;
        model_req(1, 0, 3'd4, 32'd8, 32'd0, len);
        drive(1, 0, 3'd1, 32'd10, 32'd0);
        repeat (len) @(posedge clk);
        @(posedge clk);
        #1;
        model_req(1, 0, 3'd1, 32'd10, 32'd0, len);
        Req = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        chk("held_b", last_rdata, 32'h0000_1234);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("total_dones", 32'(done_cnt), 32'(n_req));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
